// File: rtl/bubble_sort.sv
// Five-element 8-bit unsigned sorter: LOAD, ten compare-swaps (one per clock), UPDATE.
// The frame is a fixed 12 cycles with no early exit, so latency does not depend on the data.
module bubble_sort (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in1,
    input  logic [7:0] in2,
    input  logic [7:0] in3,
    input  logic [7:0] in4,
    input  logic [7:0] in5,
    output logic [7:0] out1,
    output logic [7:0] out2,
    output logic [7:0] out3,
    output logic [7:0] out4,
    output logic [7:0] out5
);

    typedef enum logic [1:0] {LOAD, SORT, UPDATE} state_t;

    state_t          state;
    logic [4:0][7:0] w;
    logic [1:0]      p;
    logic [1:0]      i;
    logic [2:0]      ia;
    logic [2:0]      ib;
    logic            swap;
    logic            pass_end;

    assign ia       = {1'b0, i};
    assign ib       = ia + 3'd1;
    // Strict compare: equal values stay in place.
    assign swap     = w[ia] > w[ib];
    assign pass_end = (i == (2'd3 - p));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LOAD;
            p     <= '0;
            i     <= '0;
            w     <= '0;
            out1  <= '0;
            out2  <= '0;
            out3  <= '0;
            out4  <= '0;
            out5  <= '0;
        end else begin
            case (state)
                LOAD: begin
                    w     <= {in5, in4, in3, in2, in1};
                    p     <= '0;
                    i     <= '0;
                    state <= SORT;
                end
                SORT: begin
                    if (swap) begin
                        w[ia] <= w[ib];
                        w[ib] <= w[ia];
                    end
                    if (pass_end) begin
                        i <= '0;
                        // p stays at 3 after the last pass; LOAD clears it.
                        if (p == 2'd3) state <= UPDATE;
                        else           p     <= p + 2'd1;
                    end else begin
                        i <= i + 2'd1;
                    end
                end
                UPDATE: begin
                    out1  <= w[0];
                    out2  <= w[1];
                    out3  <= w[2];
                    out4  <= w[3];
                    out5  <= w[4];
                    state <= LOAD;
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_bubble_sort.sv
// Bench for bubble_sort: table frames run back to back, random frames, and hand-written
// sequences for a mid-frame input change and a reset in the middle of a sort.
module tb_bubble_sort;

    typedef logic [4:0][7:0] vec5_t;
    typedef struct {
        string name;
        vec5_t vin;
        vec5_t exp;
    } tv_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in1, in2, in3, in4, in5;
    logic [7:0] out1, out2, out3, out4, out5;

    int    nchk  = 0;
    int    nfail = 0;
    vec5_t sb[$];
    tv_t   tbl[5];

    always #5 clk = ~clk;

    bubble_sort dut (
        .clk (clk),  .rst (rst),
        .in1 (in1),  .in2 (in2),  .in3 (in3),  .in4 (in4),  .in5 (in5),
        .out1(out1), .out2(out2), .out3(out3), .out4(out4), .out5(out5)
    );

    function automatic vec5_t mk(input int a, input int b, input int c, input int d, input int e);
        vec5_t v;
        v[0] = a[7:0]; v[1] = b[7:0]; v[2] = c[7:0]; v[3] = d[7:0]; v[4] = e[7:0];
        return v;
    endfunction

    // Reference ordering by repeated minimum selection.
    function automatic vec5_t model_sort(input vec5_t v);
        vec5_t r;
        logic [7:0] t;
        r = v;
        for (int a = 0; a < 4; a++)
            for (int b = a + 1; b < 5; b++)
                if (r[b] < r[a]) begin
                    t = r[a]; r[a] = r[b]; r[b] = t;
                end
        return r;
    endfunction

    task automatic set_in(input vec5_t v);
        in1 = v[0]; in2 = v[1]; in3 = v[2]; in4 = v[3]; in5 = v[4];
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input vec5_t exp);
        vec5_t act;
        act = {out5, out4, out3, out2, out1};
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d,%0d,%0d,%0d,%0d expected %0d,%0d,%0d,%0d,%0d", name,
                     act[0], act[1], act[2], act[3], act[4],
                     exp[0], exp[1], exp[2], exp[3], exp[4]);
        end
    endtask

    task automatic chk_pop(input string name);
        vec5_t exp;
        if (sb.size() == 0) begin
            nchk++;
            nfail++;
            $display("FAIL %s: scoreboard empty, no expected frame", name);
        end else begin
            exp = sb.pop_front();
            chk(name, exp);
        end
    endtask

    // Entered at the negedge before a LOAD edge; leaves at the negedge after that frame's UPDATE.
    task automatic run_frame(input string name, input vec5_t vin, input vec5_t exp, input vec5_t prev);
        set_in(vin);
        sb.push_back(exp);
        tick();                        // LOAD
        repeat (10) tick();            // ten compare-swaps
        chk({name, "_hold"}, prev);    // outputs must not move before UPDATE
        tick();                        // UPDATE
        chk_pop(name);
    endtask

    initial begin
        vec5_t prev;
        vec5_t v;

        tbl[0] = '{"basic",   mk(16, 14, 15, 17, 12),  mk(12, 14, 15, 16, 17)};
        tbl[1] = '{"sorted",  mk(1, 2, 3, 4, 5),       mk(1, 2, 3, 4, 5)};
        tbl[2] = '{"reverse", mk(255, 200, 128, 1, 0), mk(0, 1, 128, 200, 255)};
        tbl[3] = '{"dups",    mk(7, 3, 7, 3, 7),       mk(3, 3, 7, 7, 7)};
        tbl[4] = '{"equal",   mk(9, 9, 9, 9, 9),       mk(9, 9, 9, 9, 9)};

        rst = 1'b1;
        set_in(mk(0, 0, 0, 0, 0));
        repeat (3) tick();
        chk("reset", '0);

        // Table frames, back to back from one reset release.
        rst  = 1'b0;
        prev = '0;
        for (int k = 0; k < 5; k++) begin
            run_frame(tbl[k].name, tbl[k].vin, tbl[k].exp, prev);
            prev = tbl[k].exp;
        end

        // Random frames continue the same free-running sequence.
        for (int k = 0; k < 6; k++) begin
            v = mk($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                   $urandom_range(0, 255), $urandom_range(0, 255));
            run_frame("random", v, model_sort(v), prev);
            prev = model_sort(v);
        end

        // Inputs changing during SORT only affect the following frame.
        rst = 1'b1;
        tick();
        chk("reset2", '0);
        rst = 1'b0;
        set_in(mk(5, 4, 3, 2, 1));
        sb.push_back(mk(1, 2, 3, 4, 5));
        tick();                          // E0
        repeat (4) tick();               // E1..E4
        set_in(mk(50, 40, 30, 20, 10));  // sampled next at E12
        sb.push_back(mk(10, 20, 30, 40, 50));
        repeat (6) tick();               // E5..E10
        chk("midchg_e10", '0);
        tick();                          // E11
        chk_pop("midchg_f0");
        repeat (11) tick();              // E12..E22
        chk("midchg_hold", mk(1, 2, 3, 4, 5));
        tick();                          // E23
        chk_pop("midchg_f1");

        // Reset during the second frame's SORT discards that frame.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        run_frame("mrst_basic", mk(16, 14, 15, 17, 12), mk(12, 14, 15, 16, 17), '0);
        repeat (5) tick();               // E12..E16, second frame loaded and sorting
        chk("mrst_before", mk(12, 14, 15, 16, 17));
        rst = 1'b1;
        tick();                          // E17
        chk("mrst_e17", '0);
        tick();                          // E18
        rst = 1'b0;                      // E19 is the new LOAD
        run_frame("mrst_after", mk(9, 8, 7, 6, 5), mk(5, 6, 7, 8, 9), '0);

        nchk++;
        if (sb.size() != 0) begin
            nfail++;
            $display("FAIL sb_drain: got %0d leftover frames expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
